// File: rtl/mmul_parallel_out_collector.sv
// mmul_parallel_out_collector: job-length-aware output FIFO between the MMUL_PARALLEL engine and the output streamer.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           synchronous soft clear (highest priority, flushes the FIFO)
//   start_i, len_i    job start pulse and word count sampled on an accepted start
//   in_*              stream sink from the engine (valid/ready/data/strb)
//   out_*             stream source to the output streamer (valid/ready/data/strb)
//   busy_o            job in progress
//   done_o            one-cycle pulse the cycle after the last word leaves
//   cnt_o             words delivered in the current or last job
//   level_o           FIFO occupancy
//   err_o             sticky overrun flag
//
// Optional feature macro: MMUL_PARALLEL_OUT_OVF_CHECK_EN
//   defined   : outside RUN the sink accepts and discards words, setting err_o
//   undefined : outside RUN the sink stalls and err_o is constant 0
module mmul_parallel_out_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [31:0]                len_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  input  logic [DATA_WIDTH/8-1:0]    in_strb_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [DATA_WIDTH/8-1:0]    out_strb_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                cnt_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [31:0]           r_len, r_in_cnt, r_out_cnt;
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [SW-1:0]         r_strb [DEPTH];
  logic                  w_run, w_push, w_pop, w_start, w_last_in, w_last_out;

  assign w_run = (r_state == RUN);

`ifdef MMUL_PARALLEL_OUT_OVF_CHECK_EN
  // Outside RUN the sink swallows excess words so the engine never hangs.
  assign in_ready_o = w_run ? (r_level < LW'(DEPTH)) : 1'b1;
`else
  assign in_ready_o = w_run && (r_level < LW'(DEPTH));
`endif

  assign out_valid_o = (r_level != '0);
  assign out_data_o  = r_data[r_rptr];
  assign out_strb_o  = r_strb[r_rptr];
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign cnt_o       = r_out_cnt;
  assign level_o     = r_level;

  assign w_push     = in_valid_i && in_ready_o && w_run;
  assign w_pop      = out_valid_o && out_ready_i;
  assign w_start    = start_i && (r_state == IDLE);
  assign w_last_in  = w_push && (r_in_cnt + 32'd1 == r_len);
  assign w_last_out = w_pop && (r_state == DRAIN) && (r_out_cnt + 32'd1 == r_len);

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = clear_i                           ? IDLE  :
                  (w_start && len_i != 32'd0)       ? RUN   :
                  w_last_in                         ? DRAIN :
                  w_last_out                        ? IDLE  : r_state;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_done    <= 1'b0;
    end else if (clear_i) begin
      r_len     <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_done    <= 1'b0;
    end else begin
      // A zero-length start completes immediately without leaving IDLE.
      r_done <= w_last_out || (w_start && len_i == 32'd0);
      if (w_start) begin
        r_len     <= len_i;
        r_in_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_push) r_in_cnt <= r_in_cnt + 32'd1;
        if (w_pop) r_out_cnt <= r_out_cnt + 32'd1;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= in_data_i;
      r_strb[r_wptr] <= in_strb_i;
    end
  end

`ifdef MMUL_PARALLEL_OUT_OVF_CHECK_EN
  logic r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                             r_err <= 1'b0;
    else if (clear_i)                        r_err <= 1'b0;
    else if (in_valid_i && in_ready_o && !w_run) r_err <= 1'b1;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: doc/mmul_parallel_out_collector.md
# mmul_parallel_out_collector

Output stage placed directly downstream of the MMUL_PARALLEL engine's `out_r` source port and upstream of the output streamer sink. It buffers result words in a small FIFO, so short back-pressure from the streamer does not stall the kernel. It counts words against a per-job length captured at start and raises a one-cycle job-done pulse once the last word has left toward memory. Control inputs come from the same control registers that drive the engine.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of the stream data; strobe width is `DATA_WIDTH/8`.
- `DEPTH`, 4: number of FIFO entries; must be a power of two and at least 2.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous soft clear.
- `start_i`  in  1  job start pulse.
- `len_i`  in  32  number of words in the job; sampled on accepted start.
- `in`  sink  hwpe_stream_intf_stream (`DATA_WIDTH`)  results from the engine.
- `out`  source  hwpe_stream_intf_stream (`DATA_WIDTH`)  results to the output streamer.
- `busy_o`  out  1  job in progress.
- `done_o`  out  1  one-cycle job completion pulse.
- `cnt_o`  out  32  words delivered on `out` in the current or last job.
- `level_o`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `err_o`  out  1  sticky overrun flag; only present in function with the macro defined, otherwise tied to 0.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - `start_i` with `len_i != 0`: latch `len_i`, zero both counters, go to RUN.
  - `start_i` with `len_i == 0`: `done_o` pulses the next cycle; state stays IDLE.
- RUN:
  - `in.ready = (level < DEPTH)`.
  - Each `in` handshake pushes data and strb, and increments `in_cnt`.
  - When the push makes `in_cnt == len`, go to DRAIN.
- DRAIN:
  - `in.ready = 0`, except as described under Configuration.
  - When an `out` handshake makes `out_cnt == len`, `done_o` pulses next cycle and the state returns to IDLE.
- `out.valid = (level != 0)`; `out.data`/`out.strb` carry the FIFO head. Order is preserved and strb passes through unmodified.
- In IDLE, `in.ready = 0`.
- `cnt_o = out_cnt`. It holds its value after done until the next accepted start or a clear.
- `busy_o = (state != IDLE)`.
- `start_i` in RUN or DRAIN is ignored; the latched length is not altered.
- Push and pop in the same cycle leave the level unchanged. Pointers wrap modulo `DEPTH`.
- Counters are 32-bit unsigned. `len` up to 2^32-1 is legal; there is no counter wrap within a job.

## Timing
- Reset values: `busy_o=0`, `done_o=0`, `cnt_o=0`, `level_o=0`, `err_o=0`, `out.valid=0`, `in.ready=0`; state is IDLE and pointers are 0.
- `clear_i` has priority over everything else. It produces the same state as reset, effective on the next edge, and drops any buffered words.
- Reset asserted mid-job: immediate return to the reset state; no `done_o` is produced.
- Latency: a word accepted on `in` at edge t is presented on `out.valid` after edge t, so it can be popped at edge t+1.
- `in.ready` and `out.valid` are derived from registered state only; there is no combinational path from `out.ready` to `in.ready`.
- Full FIFO: `in.ready=0` even if `out.ready=1` in the same cycle.
- Throughput is 1 word/cycle with `out.ready` held high.
- `done_o` is high for exactly one cycle: the cycle after the final `out` handshake. `busy_o` falls in that same cycle.
- `out.valid`, once raised, stays high with stable data until the handshake completes.

## Configuration
- Macro: `MMUL_PARALLEL_OUT_OVF_CHECK_EN`.
- Defined:
  - In DRAIN and IDLE, `in.ready=1`.
  - Any `in` handshake there discards the word, does not touch the FIFO, and sets `err_o`.
  - `err_o` is sticky until `clear_i` or reset.
- Not defined:
  - Excess words stall upstream (`in.ready=0`).
  - `err_o` is constant 0 and no overrun logic is generated.

## Test plan
- Reset, then `start_i` with `len_i=8`; drive 8 words 0x1..0x8 back-to-back with `out.ready=1`:
  - the same 8 words appear in order, one per cycle, each one cycle after its input;
  - `done_o` pulses once, the cycle after the 8th pop;
  - `cnt_o=8`, `busy_o=0`.
- `DEPTH=4`, `len_i=6`, `out.ready=0`:
  - after 4 pushes, `level_o=4` and `in.ready=0`;
  - release `out.ready` and all 6 words drain in order;
  - `done_o` pulses once.
- `start_i` with `len_i=0` -> `done_o` pulses next cycle; `busy_o` never rises; `cnt_o=0`.
- `len_i=3`; assert `clear_i` after 2 pushes -> next cycle `level_o=0`, `busy_o=0`, `cnt_o=0`; no `done_o`.
- Second `start_i` with `len_i=5` issued mid-job of length 4 -> ignored; `done_o` fires after exactly 4 pops.
- Macro defined, `len_i=2`, 3 words offered -> 3rd word accepted and dropped; `err_o=1` until `clear_i`; `out` sees only 2 words. Macro undefined -> 3rd word stalls with `in.ready=0`.
